// File: rtl/wide_sub_sched.sv
// Shared-subtractor scheduler: round-robin arbitration of NREQ requesters
// onto one 8-bit subtractor, processing a BYTES*8-bit subtraction one byte
// per cycle (LSB first) with the borrow chained between bytes.

// Plain 8-bit subtractor; Borrow is set when a < b (unsigned).
module subtractor_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       Borrow
);
  logic [8:0] w_full;

  // Nine-bit difference: the top bit is the borrow out of bit 7
  assign w_full = {1'b0, a} - {1'b0, b};
  assign diff   = w_full[7:0];
  assign Borrow = w_full[8];
endmodule

module wide_sub_sched #(
  parameter int NREQ  = 4,
  parameter int BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BYTES*8-1:0]  req_a,
  input  logic [NREQ*BYTES*8-1:0]  req_b,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [BYTES*8-1:0]       result,
  output logic                     borrow_out,
  output logic                     busy
);
  localparam int W  = BYTES * 8;
  localparam int PW = $clog2(NREQ);
  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Registered state
  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [KW-1:0]   r_k;
  logic            r_bw;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [W-1:0]    r_result;
  logic            r_borrow_out;
  logic            r_busy;

  // Next-state values
  state_t          w_state_next;
  logic [PW-1:0]   w_ptr_next;
  logic [KW-1:0]   w_k_next;
  logic            w_bw_next;
  logic [W-1:0]    w_a_next;
  logic [W-1:0]    w_b_next;
  logic [NREQ-1:0] w_gnt_next;
  logic [NREQ-1:0] w_done_next;
  logic [W-1:0]    w_result_next;
  logic            w_borrow_out_next;
  logic            w_busy_next;

  // Arbiter signals
  logic [PW:0]     w_sum     [NREQ];
  logic [PW-1:0]   w_idx     [NREQ];
  logic [NREQ-1:0] w_rot;
  logic [W-1:0]    w_req_a   [NREQ];
  logic [W-1:0]    w_req_b   [NREQ];
  logic [PW-1:0]   w_winner;
  logic [PW-1:0]   w_ptr_after;
  logic [NREQ-1:0] w_win_1h;

  // Byte datapath signals
  logic [7:0]      w_a_byte  [BYTES];
  logic [7:0]      w_b_byte  [BYTES];
  logic [7:0]      w_ak;
  logic [7:0]      w_bk;
  logic [7:0]      w_bk_adj;
  logic [7:0]      w_sub_diff;
  logic            w_sub_borrow;
  logic            w_fold;
  logic [7:0]      w_diff;
  logic            w_bw_new;

  genvar gi;

  // Rotate the request vector so position 0 is the requester at r_ptr;
  // also unpack the per-requester operand buses.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_sum[gi]   = {1'b0, r_ptr} + (PW+1)'(gi);
      assign w_idx[gi]   = (w_sum[gi] >= (PW+1)'(NREQ))
                           ? PW'(w_sum[gi] - (PW+1)'(NREQ))
                           : w_sum[gi][PW-1:0];
      assign w_rot[gi]   = req[w_idx[gi]];
      assign w_req_a[gi] = req_a[gi*W +: W];
      assign w_req_b[gi] = req_b[gi*W +: W];
      assign w_win_1h[gi] = (w_winner == PW'(gi));
    end
  endgenerate

  // First pending requester at or after r_ptr (lowest rotated position) wins
  always_comb begin
    w_winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_winner = w_idx[i];
      end
    end
  end

  assign w_ptr_after = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

  // Split the latched operands into byte lanes
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_byte
      assign w_a_byte[gi] = r_a[gi*8 +: 8];
      assign w_b_byte[gi] = r_b[gi*8 +: 8];
    end
  endgenerate

  assign w_ak     = w_a_byte[r_k];
  assign w_bk     = w_b_byte[r_k];
  // Incoming borrow is folded into the subtrahend byte
  assign w_bk_adj = w_bk + {7'd0, r_bw};

  subtractor_8b u_sub (
    .a      (w_ak),
    .b      (w_bk_adj),
    .diff   (w_sub_diff),
    .Borrow (w_sub_borrow)
  );

  // B byte 0xFF plus an incoming borrow wraps to 0: the true result is
  // Ak - 256, i.e. the same byte with the borrow propagated onward.
  assign w_fold   = r_bw & (w_bk == 8'hFF);
  assign w_diff   = w_fold ? w_ak : w_sub_diff;
  assign w_bw_new = w_fold ? 1'b1 : w_sub_borrow;

  // Next-state and output decode for IDLE / RUN / DONE
  always_comb begin
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_k_next          = r_k;
    w_bw_next         = r_bw;
    w_a_next          = r_a;
    w_b_next          = r_b;
    w_gnt_next        = r_gnt;
    w_done_next       = '0;
    w_result_next     = r_result;
    w_borrow_out_next = r_borrow_out;
    w_busy_next       = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_next = ST_RUN;
          w_a_next     = w_req_a[w_winner];
          w_b_next     = w_req_b[w_winner];
          w_gnt_next   = w_win_1h;
          w_k_next     = '0;
          w_bw_next    = 1'b0;
          w_ptr_next   = w_ptr_after;
          w_busy_next  = 1'b1;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < BYTES; j++) begin
          if (r_k == KW'(j)) begin
            w_result_next[j*8 +: 8] = w_diff;
          end
        end
        w_k_next  = r_k + 1'b1;
        w_bw_next = w_bw_new;
        if (r_k == KW'(BYTES - 1)) begin
          w_state_next      = ST_DONE;
          w_gnt_next        = '0;
          w_done_next       = r_gnt;
          w_borrow_out_next = w_bw_new;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_k          <= '0;
      r_bw         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_result     <= '0;
      r_borrow_out <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_next;
      r_k          <= w_k_next;
      r_bw         <= w_bw_next;
      r_a          <= w_a_next;
      r_b          <= w_b_next;
      r_gnt        <= w_gnt_next;
      r_done       <= w_done_next;
      r_result     <= w_result_next;
      r_borrow_out <= w_borrow_out_next;
      r_busy       <= w_busy_next;
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign result     = r_result;
  assign borrow_out = r_borrow_out;
  assign busy       = r_busy;

endmodule

// File: tb/tb_wide_sub_sched.sv
// Testbench for wide_sub_sched: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_wide_sub_sched;
  localparam int NREQ  = 4;
  localparam int BYTES = 4;
  localparam int W     = BYTES * 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [W-1:0]        result;
  logic                borrow_out;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: phase 0 = idle, 1..BYTES = granted, BYTES+1 = done
  int          m_phase;
  int          m_win;
  int          m_ptr;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_result;
  logic         m_borrow;

  int done_log[$];
  int done_cycles[$];

  wide_sub_sched #(.NREQ(NREQ), .BYTES(BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .borrow_out (borrow_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_ptr    = 0;
    m_win    = 0;
    m_a      = '0;
    m_b      = '0;
    m_result = '0;
    m_borrow = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_edge();
    int  j;
    bit  found;
    if (m_phase == 0) begin
      if (req != '0) begin
        found = 0;
        for (int i = 0; i < NREQ; i++) begin
          j = (m_ptr + i) % NREQ;
          if (!found && req[j]) begin
            m_win = j;
            found = 1;
          end
        end
        m_a     = req_a[m_win*W +: W];
        m_b     = req_b[m_win*W +: W];
        m_ptr   = (m_win + 1) % NREQ;
        m_phase = 1;
      end
    end else if (m_phase == BYTES) begin
      m_result = m_a - m_b;
      m_borrow = (m_a < m_b);
      m_phase  = BYTES + 1;
    end else if (m_phase == BYTES + 1) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ed;
    oh = '0;
    oh[m_win] = 1'b1;
    eg = (m_phase >= 1 && m_phase <= BYTES) ? oh : '0;
    ed = (m_phase == BYTES + 1) ? oh : '0;
    chk("gnt", gnt, eg);
    chk("done", done, ed);
    chk("busy", busy, (m_phase != 0));
    chk("borrow_out", borrow_out, m_borrow);
    // result only changes on RUN edges after byte 0; stable in these phases
    if (m_phase == 0 || m_phase == 1 || m_phase == BYTES + 1)
      chk("result", result, m_result);
  endtask

  // One clock: model edge, DUT edge, compare at the falling edge
  task automatic cycle();
    if (!rst) model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
    if (done != '0) begin
      done_cycles.push_back(cyc);
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          done_log.push_back(i);
          $display("op req%0d a=%08h b=%08h result=%08h borrow=%0d cycle=%0d",
                   i, m_a, m_b, result, borrow_out, cyc);
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    model_reset();
    #1;
    compare();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Single requester operation from IDLE with explicit expected values
  task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_bw);
    int n;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req[idx] = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!done[idx] && n < 20);
    chk("op_latency", n, BYTES + 1);
    chk("op_result", result, exp_res);
    chk("op_borrow", borrow_out, exp_bw);
    cycle();
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = W'($urandom_range(0, 3));
      1: begin
        v = $urandom;
        for (int i = 0; i < BYTES; i++)
          if ($urandom_range(0, 1) == 0) v[i*8 +: 8] = 8'hFF;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    rst   = 1'b1;
    req   = '0;
    req_a = '0;
    req_b = '0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Directed arithmetic cases
    run_op(0, 32'h12345678, 32'h00000001, 32'h12345677, 1'b0);
    run_op(0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1);
    run_op(0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
    run_op(0, 32'h12340000, 32'h0000FF01, 32'h123300FF, 1'b0);
    run_op(0, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b1);

    // Round-robin from a fresh reset with all four requesting
    do_reset();
    done_log.delete();
    done_cycles.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = rand_word();
      req_b[i*W +: W] = rand_word();
    end
    req = '1;
    n = 0;
    while (done_log.size() < 4 && n < 60) begin
      cycle();
      n++;
    end
    chk("rr_count", done_log.size(), 4);
    for (int i = 0; i < 4 && i < done_log.size(); i++) chk("rr_order", done_log[i], i);
    for (int i = 1; i < done_cycles.size(); i++)
      chk("rr_gap", done_cycles[i] - done_cycles[i-1], 6);
    cycle();

    // Requesters 0 and 2 with the pointer back at 0
    done_log.delete();
    req[0] = 1'b1;
    req[2] = 1'b1;
    n = 0;
    while (done_log.size() < 2 && n < 40) begin
      cycle();
      n++;
    end
    chk("rr2_count", done_log.size(), 2);
    if (done_log.size() == 2) begin
      chk("rr2_first", done_log[0], 0);
      chk("rr2_second", done_log[1], 2);
    end
    cycle();

    // Operand change and request drop mid-operation; late request from 1
    done_log.delete();
    req_a[0*W +: W] = 32'hA5A50000;
    req_b[0*W +: W] = 32'h00010001;
    req[0] = 1'b1;
    cycle();
    cycle();
    req_a[0*W +: W] = 32'hFFFFFFFF;
    req[0] = 1'b0;
    req_a[1*W +: W] = 32'h00000007;
    req_b[1*W +: W] = 32'h00000009;
    req[1] = 1'b1;
    n = 0;
    while (done_log.size() < 1 && n < 20) begin
      cycle();
      n++;
    end
    chk("mid_done", done_log.size(), 1);
    chk("mid_result", result, 32'hA5A3FFFF);
    chk("mid_borrow", borrow_out, 1'b0);
    cycle();
    cycle();
    chk("late_gnt", gnt, 4'b0010);
    n = 0;
    while (done_log.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("late_result", result, 32'hFFFFFFFE);
    chk("late_borrow", borrow_out, 1'b1);
    cycle();

    // Reset in the third RUN cycle abandons the operation
    done_log.delete();
    req_a[2*W +: W] = 32'h11111111;
    req_b[2*W +: W] = 32'h22222222;
    req[2] = 1'b1;
    cycle();
    cycle();
    cycle();
    do_reset();
    cycle();
    cycle();
    chk("rst_no_done", done_log.size(), 0);
    req_a[1*W +: W] = 32'h00000100;
    req_b[1*W +: W] = 32'h00000001;
    req_a[3*W +: W] = 32'h00000200;
    req_b[3*W +: W] = 32'h00000002;
    req[1] = 1'b1;
    req[3] = 1'b1;
    n = 0;
    while (done_log.size() < 1 && n < 20) begin
      cycle();
      n++;
    end
    chk("post_rst_winner", (done_log.size() > 0) ? done_log[0] : -1, 1);
    chk("post_rst_result", result, 32'h000000FF);

    // Randomized traffic including mid-operation operand disturbances
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_a[i*W +: W] = rand_word();
          req_b[i*W +: W] = ($urandom_range(0, 5) == 0) ? req_a[i*W +: W] : rand_word();
          req[i] = 1'b1;
        end
      end
      if (m_phase >= 1 && m_phase <= BYTES && $urandom_range(0, 7) == 0) begin
        req_a[m_win*W +: W] = $urandom;
        req_b[m_win*W +: W] = $urandom;
        if ($urandom_range(0, 1) == 0) req[m_win] = 1'b0;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_sub_sched.md
# wide_sub_sched

Shared-subtractor scheduler for the compute unit. Up to `NREQ` requesters share one `subtractor_8b` instance through a round-robin arbiter. The block performs `BYTES*8`-bit subtractions one byte per cycle, least-significant byte first, and chains the borrow between bytes. It returns the wide difference and the final borrow to the winning requester with a one-cycle done pulse.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `BYTES`, 4: operand width in bytes (1..8). Operand width `W = BYTES*8`.

Ports:
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: per-requester request level.
- `req_a` in NREQ*W: minuends, requester i at `[i*W +: W]`.
- `req_b` in NREQ*W: subtrahends, same packing.
- `gnt` out NREQ: one-hot, high for the whole operation of the granted requester.
- `done` out NREQ: one-hot, one-cycle pulse to the granted requester when the result is valid.
- `result` out W: `A - B` modulo `2^W`.
- `borrow_out` out 1: 1 when `A < B` (unsigned).
- `busy` out 1: high whenever the state is not IDLE.

## Operation
The block has three states: IDLE, RUN and DONE.

- **IDLE**
  - If `req` is non-zero, select the winner: the first set bit scanning upward from `ptr` and wrapping mod `NREQ`.
  - Latch the winner's A and B, set `gnt` to the winner's one-hot, clear the byte index `k` and the borrow register `bw`, and go to RUN.
  - Set `ptr` to `(winner+1) mod NREQ`.
  - If `req` is zero, stay in IDLE. `ptr` is unchanged.
- **RUN**, one byte per cycle:
  - Inputs to `subtractor_8b`:
    - `Ak = A[k*8+:8]`
    - `Bk' = B[k*8+:8] + bw` (8-bit).
  - Borrow-in folding rule:
    - If `bw=1` and `B[k*8+:8]=8'hFF`, then `diff=Ak` and the new `bw=1`. The subtractor output is ignored.
    - Otherwise `diff=subtractor.diff` and the new `bw=subtractor.Borrow`.
  - Write `diff` into `result[k*8+:8]` and increment `k`.
  - After the byte with `k=BYTES-1`: clear `gnt`, set `borrow_out` to the new `bw`, and go to DONE.
- **DONE**: `done` equals the one-hot of the last winner for exactly this cycle, then return to IDLE.

Requester and hold rules:
- A requester holds `req`, `req_a` and `req_b` stable from asserting `req` until its `done` pulse.
- A requester drops `req` on the edge that ends the `done` cycle.
- Operands are latched at grant. Later changes to `req_a`/`req_b` or a deassertion of `req` do not affect an operation in progress. The operation always completes and pulses `done`.
- Requests arriving during RUN or DONE wait. They are only arbitrated in IDLE.

Reset (asynchronous, any state, including mid-RUN):
- state=IDLE, `ptr=0`, `k=0`, `bw=0`.
- `gnt=0`, `done=0`, `result=0`, `borrow_out=0`, `busy=0`.
- An operation in progress is abandoned with no `done` pulse.

## Timing
- `req` is sampled at the edge ending cycle 0, when the state is IDLE.
- `gnt` and `busy` are high in cycles 1..BYTES.
- `done` is high in cycle BYTES+1. `busy` stays high in DONE.
- The state is IDLE in cycle BYTES+2, which is the earliest cycle in which the next grant can be sampled.
- Request-to-done latency is BYTES+1 cycles. Throughput is one operation per BYTES+2 cycles.
- `result` and `borrow_out` are valid from the `done` cycle. They are held until the first RUN edge of the next operation, when byte 0 of `result` is overwritten.
- All outputs are registered. There is no combinational path from `req` to `gnt`.

## Test plan
All scenarios use `BYTES=4` and `NREQ=4`.

- **Basic subtract:** req[0], A=0x12345678, B=0x00000001 → gnt[0] high cycles 1-4, done[0] in cycle 5, result=0x12345677, borrow_out=0.
- **Underflow:** A=0x00000000, B=0x00000001 → result=0xFFFFFFFF, borrow_out=1. Also A=0x00000005, B=0x00000005 → result=0, borrow_out=0.
- **Borrow fold on 0xFF byte:** A=0x12340000, B=0x0000FF01 → result=0x123300FF, borrow_out=0. Also A=0x00000000, B=0xFFFFFFFF → result=0x00000001, borrow_out=1.
- **Round-robin:** after reset, req=4'b1111 held, each requester dropping `req` after its `done` → grant order 0, 1, 2, 3.
  - Continue with req=4'b0101 re-asserted while ptr=0 → grant 0, then 2.
  - Gap between consecutive `done` pulses is exactly 6 cycles.
- **Operand and request changes mid-operation:** change `req_a` and deassert `req` during cycle 2 of RUN → result reflects the latched operands and `done` still pulses.
  - req[1] asserted during RUN of requester 0 → requester 1 is granted in the cycle after IDLE is re-entered.
- **Reset mid-operation:** assert `rst` in cycle 3 of RUN → all outputs 0 immediately, no `done` pulse.
  - After release, a new request completes normally with ptr=0 priority.
